stage_controller: RTL

//  Top-level game sequencer. Tracks which screen is live (start, countdown, fight, win, lose)
//  and drives the one-hot stage flags consumed by color_mapper.

---
 rtl/stage_controller_pkg.sv | 19 +
 rtl/stage_controller_if.sv | 28 ++
 rtl/stage_controller_frame_tick_gen.sv | 28 ++
 rtl/stage_controller.sv | 117 +++++++++++
 4 files changed

// File: rtl/stage_controller_pkg.sv
// Shared stage encodings and keycodes for the game sequencer, its colour mapper
// wrapper and the bench.
package stage_controller_pkg;

    typedef logic [2:0] stage_t;

    localparam stage_t S_START = 3'd0;
    localparam stage_t S_COUNT = 3'd1;
    localparam stage_t S_GAME  = 3'd2;
    localparam stage_t S_WIN   = 3'd3;
    localparam stage_t S_LOSE  = 3'd4;

    localparam logic [7:0] KEY_ENTER = 8'h28;

    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/stage_controller_if.sv
// Bundle between keyboard/health logic, the stage controller and color_mapper.
interface stage_controller_if #(
    parameter int unsigned HP_W = 4
) ();

    logic            frame_clk;
    logic [7:0]      keycode;
    logic [HP_W-1:0] p1_hp;
    logic [HP_W-1:0] p2_hp;
    logic            start_l;
    logic            game_l;
    logic            win_l;
    logic            lose_l;
    logic            freeze;
    logic            round_rst;
    logic [7:0]      count_val;

    modport master (
        output frame_clk, keycode, p1_hp, p2_hp,
        input  start_l, game_l, win_l, lose_l, freeze, round_rst, count_val
    );

    modport slave (
        input  frame_clk, keycode, p1_hp, p2_hp,
        output start_l, game_l, win_l, lose_l, freeze, round_rst, count_val
    );

endinterface

// File: rtl/stage_controller_frame_tick_gen.sv
// Brings the vsync-derived frame signal into the Clk domain and emits one
// registered Clk pulse per rising edge.
module stage_controller_frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk_i,
    output logic tick_o
);

    logic sync1_q, sync2_q, prev_q, tick_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= sync2_q & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/stage_controller.sv
// Game sequencer: start -> countdown -> fight -> win/lose -> start, with
// registered one-hot stage flags, motion freeze and a one-Clk round reset.
module stage_controller
    import stage_controller_pkg::*;
#(
    parameter int unsigned HP_W         = 4,
    parameter int unsigned COUNT_FRAMES = 180,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter logic [7:0]  KEY_START    = KEY_ENTER
) (
    input  logic Clk,
    input  logic Reset_n,
    stage_controller_if.slave ctrl_io
);

    localparam int unsigned CNT_MAX = (COUNT_FRAMES > HOLD_FRAMES) ? COUNT_FRAMES : HOLD_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    stage_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enter_q;
    logic             tick, press, p1_dead, p2_dead;
    logic             start_q, game_q, win_q, lose_q, freeze_q, round_rst_q;
    logic [7:0]       count_val_q;

    stage_controller_frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk_i(ctrl_io.frame_clk),
        .tick_o     (tick)
    );

    // Holding Enter counts once: only the first Clk of a hold is a press.
    assign press   = (ctrl_io.keycode == KEY_START) && !enter_q;
    assign p1_dead = (ctrl_io.p1_hp == {HP_W{1'b0}});
    assign p2_dead = (ctrl_io.p2_hp == {HP_W{1'b0}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_START: begin
                if (press) begin
                    state_d = S_COUNT;
                    cnt_d   = CNT_W'(COUNT_FRAMES);
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_GAME;
                        cnt_d   = CNT_W'(HOLD_FRAMES);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_GAME: begin
                if (p1_dead) begin
                    state_d = S_LOSE;
                    cnt_d   = CNT_W'(HOLD_FRAMES);
                end else if (p2_dead) begin
                    state_d = S_WIN;
                    cnt_d   = CNT_W'(HOLD_FRAMES);
                end
            end
            S_WIN, S_LOSE: begin
                // A press during the hold window is dropped, not remembered.
                if (press && (cnt_q == '0)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else if (tick && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_START;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_START;
            cnt_q       <= '0;
            enter_q     <= 1'b0;
            start_q     <= 1'b1;
            game_q      <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            freeze_q    <= 1'b1;
            round_rst_q <= 1'b0;
            count_val_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enter_q     <= (ctrl_io.keycode == KEY_START);
            start_q     <= (state_d == S_START);
            game_q      <= (state_d == S_COUNT) || (state_d == S_GAME);
            win_q       <= (state_d == S_WIN);
            lose_q      <= (state_d == S_LOSE);
            freeze_q    <= (state_d != S_GAME);
            round_rst_q <= (state_q == S_START) && (state_d == S_COUNT);
            count_val_q <= (state_d == S_COUNT) ? sat8(32'(cnt_d)) : 8'h00;
        end
    end

    assign ctrl_io.start_l   = start_q;
    assign ctrl_io.game_l    = game_q;
    assign ctrl_io.win_l     = win_q;
    assign ctrl_io.lose_l    = lose_q;
    assign ctrl_io.freeze    = freeze_q;
    assign ctrl_io.round_rst = round_rst_q;
    assign ctrl_io.count_val = count_val_q;

endmodule
